// File: rtl/mipi_tx_lane_distributor_if.sv
// Packet-side handshake of the MIPI TX lane distributor: start/length request
// plus the LANES-byte payload word stream.
interface mipi_tx_lane_distributor_if #(
    parameter int unsigned LANES = 4
);
    logic                 start;
    logic [15:0]          packet_len;
    logic [8*LANES-1:0]   data;
    logic                 data_valid;
    logic                 data_ready;

    // Packet builder side
    modport master (
        output start,
        output packet_len,
        output data,
        output data_valid,
        input  data_ready
    );

    // Distributor side
    modport slave (
        input  start,
        input  packet_len,
        input  data,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/mipi_tx_lane_distributor.sv
// MIPI CSI transmit lane distributor: frames a packet on LANES byte lanes as
// HS-zero preamble, sync byte, round-robin payload bytes and a per-lane trail.
// The FSM state names the phase the *next* clock edge emits, so the first
// preamble byte leaves on the start edge and DATA (ready high) overlaps the
// cycle in which the sync byte is on the lanes.
module mipi_tx_lane_distributor #(
    parameter int unsigned LANES          = 4,
    parameter int unsigned HS_ZERO_CYCLES = 6,
    parameter int unsigned TRAIL_CYCLES   = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hB8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    mipi_tx_lane_distributor_if.slave   pkt_if,
    output logic [8*LANES-1:0]          lane_byte_o,
    output logic [LANES-1:0]            lane_valid_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        underrun_o
);

    localparam int unsigned PrepW  = $clog2(HS_ZERO_CYCLES + 1);
    localparam int unsigned TrailW = $clog2(TRAIL_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StPrep, StSync, StData, StTrail} state_e;

    state_e               state_q;
    logic [15:0]          rem_q;
    logic [PrepW-1:0]     prep_cnt_q;
    logic [7:0]           last_byte_q [LANES];
    logic [TrailW-1:0]    trail_cnt_q [LANES];
    logic [8*LANES-1:0]   lane_byte_q;
    logic [LANES-1:0]     lane_valid_q;
    logic                 done_q;
    logic                 underrun_q;

    logic                 trail_any;
    logic                 trail_more;

    // Trail progress: any lane still owing bytes, and any owing more than one
    always_comb begin
        trail_any  = 1'b0;
        trail_more = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (trail_cnt_q[i] != '0) begin
                trail_any = 1'b1;
            end
            if (trail_cnt_q[i] > TrailW'(1)) begin
                trail_more = 1'b1;
            end
        end
    end

    // Framing FSM with registered lane outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            rem_q        <= '0;
            prep_cnt_q   <= '0;
            lane_byte_q  <= '0;
            lane_valid_q <= '0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) begin
                last_byte_q[i] <= '0;
                trail_cnt_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    lane_byte_q  <= '0;
                    lane_valid_q <= '0;
                    if (pkt_if.start && (pkt_if.packet_len != 16'd0)) begin
                        rem_q        <= pkt_if.packet_len;
                        underrun_q   <= 1'b0;
                        lane_valid_q <= '1;
                        prep_cnt_q   <= PrepW'(HS_ZERO_CYCLES - 1);
                        state_q      <= (HS_ZERO_CYCLES > 1) ? StPrep : StSync;
                    end
                end
                StPrep: begin
                    lane_byte_q  <= '0;
                    lane_valid_q <= '1;
                    prep_cnt_q   <= prep_cnt_q - PrepW'(1);
                    if (prep_cnt_q == PrepW'(1)) begin
                        state_q <= StSync;
                    end
                end
                StSync: begin
                    lane_byte_q  <= {LANES{SYNC_BYTE}};
                    lane_valid_q <= '1;
                    // A lane that never gets payload trails off the sync byte
                    for (int unsigned i = 0; i < LANES; i++) begin
                        last_byte_q[i] <= SYNC_BYTE;
                    end
                    state_q <= StData;
                end
                StData: begin
                    lane_valid_q <= '1;
                    if (pkt_if.data_valid) begin
                        for (int unsigned i = 0; i < LANES; i++) begin
                            if (rem_q > 16'(i)) begin
                                lane_byte_q[8*i +: 8] <= pkt_if.data[8*i +: 8];
                                last_byte_q[i]        <= pkt_if.data[8*i +: 8];
                                trail_cnt_q[i]        <= TrailW'(TRAIL_CYCLES);
                            end else begin
                                // Short lane on the final word starts its trail now
                                lane_byte_q[8*i +: 8] <= {8{~last_byte_q[i][7]}};
                                trail_cnt_q[i]        <= TrailW'(TRAIL_CYCLES - 1);
                            end
                        end
                        if (rem_q <= 16'(LANES)) begin
                            rem_q   <= '0;
                            state_q <= StTrail;
                        end else begin
                            rem_q <= rem_q - 16'(LANES);
                        end
                    end else begin
                        // Underrun: keep lanes in HS with filler, packet continues
                        lane_byte_q <= '0;
                        underrun_q  <= 1'b1;
                    end
                end
                StTrail: begin
                    for (int unsigned i = 0; i < LANES; i++) begin
                        if (trail_cnt_q[i] != '0) begin
                            lane_byte_q[8*i +: 8] <= {8{~last_byte_q[i][7]}};
                            lane_valid_q[i]       <= 1'b1;
                            trail_cnt_q[i]        <= trail_cnt_q[i] - TrailW'(1);
                        end else begin
                            lane_byte_q[8*i +: 8] <= 8'h00;
                            lane_valid_q[i]       <= 1'b0;
                        end
                    end
                    done_q <= trail_any && !trail_more;
                    if (!trail_any) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    lane_byte_q  <= '0;
                    lane_valid_q <= '0;
                end
            endcase
        end
    end

    // Ready is a pure decode of the DATA state
    always_comb begin
        pkt_if.data_ready = (state_q == StData);
    end

    assign lane_byte_o  = lane_byte_q;
    assign lane_valid_o = lane_valid_q;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = done_q;
    assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_mipi_tx_lane_distributor.sv
// Self-checking bench for mipi_tx_lane_distributor (LANES=4, 6 HS-zero, 4 trail).
module tb_mipi_tx_lane_distributor;

    localparam int unsigned LANES = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [8*LANES-1:0] lane_byte;
    logic [LANES-1:0]  lane_valid;
    logic              busy;
    logic              done;
    logic              underrun;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mipi_tx_lane_distributor_if #(.LANES(LANES)) pkt_if ();

    mipi_tx_lane_distributor #(
        .LANES          (LANES),
        .HS_ZERO_CYCLES (6),
        .TRAIL_CYCLES   (4),
        .SYNC_BYTE      (8'hB8)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .pkt_if       (pkt_if),
        .lane_byte_o  (lane_byte),
        .lane_valid_o (lane_valid),
        .busy_o       (busy),
        .done_o       (done),
        .underrun_o   (underrun)
    );

    // One packet: inputs plus hand-computed per-lane expectations.
    // nd: payload byte count per lane (nibble i = lane i)
    // lend: offset of the last valid cycle per lane (byte i = lane i)
    // trail: trail byte per lane; t is counted in edges after the start edge
    typedef struct {
        int          len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nw;
        logic [15:0] nd;
        logic [31:0] lend;
        logic [31:0] trail;
        int          done_t;
    } rec_t;

    rec_t tbl [5];

    task automatic chk(input string name, input int t, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    function automatic logic [8:0] exp_lane(input rec_t r, input int i, input int t);
        int          nd;
        int          e;
        logic [31:0] w;
        nd = int'(r.nd[4*i +: 4]);
        e  = int'(r.lend[8*i +: 8]);
        if (t <= 6) return {1'b1, 8'h00};
        if (t == 7) return {1'b1, 8'hB8};
        if (t > e) return 9'h000;
        if (t < 8 + nd) begin
            w = (t == 8) ? r.w0 : r.w1;
            return {1'b1, w[8*i +: 8]};
        end
        return {1'b1, r.trail[8*i +: 8]};
    endfunction

    // Runs one table packet with data always valid and a stray start mid-packet
    task automatic run_rec(input rec_t r, input string tag);
        int                 ptr;
        logic [8:0]         el;
        logic [8*LANES-1:0] eb;
        logic [LANES-1:0]   ev;
        @(negedge clk);
        pkt_if.start      = 1'b1;
        pkt_if.packet_len = 16'(r.len);
        pkt_if.data       = r.w0;
        pkt_if.data_valid = 1'b1;
        ptr = 0;
        for (int t = 1; t <= r.done_t + 2; t++) begin
            @(negedge clk);
            for (int i = 0; i < int'(LANES); i++) begin
                el = exp_lane(r, i, t);
                ev[i] = el[8];
                eb[8*i +: 8] = el[7:0];
            end
            chk({tag, " lane_byte"}, t, 64'(lane_byte), 64'(eb));
            chk({tag, " lane_valid"}, t, 64'(lane_valid), 64'(ev));
            chk({tag, " done"}, t, 64'(done), 64'(t == r.done_t));
            chk({tag, " busy"}, t, 64'(busy), 64'(t <= r.done_t));
            chk({tag, " ready"}, t, 64'(pkt_if.data_ready), 64'(t >= 7 && t < 7 + r.nw));
            chk({tag, " underrun"}, t, 64'(underrun), 64'(0));
            pkt_if.start      = (t <= 4);
            pkt_if.packet_len = 16'd2;
            pkt_if.data       = (ptr == 0) ? r.w0 : r.w1;
            pkt_if.data_valid = 1'b1;
            if (pkt_if.data_ready) ptr++;
        end
        pkt_if.start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{len: 8, w0: 32'h03020100, w1: 32'h07060504, nw: 2, nd: 16'h2222,
                   lend: 32'h0D0D0D0D, trail: 32'hFFFFFFFF, done_t: 13};
        tbl[1] = '{len: 5, w0: 32'h83828180, w1: 32'h000000C4, nw: 2, nd: 16'h1112,
                   lend: 32'h0C0C0C0D, trail: 32'h00000000, done_t: 13};
        tbl[2] = '{len: 1, w0: 32'h0000007F, w1: 32'h00000000, nw: 1, nd: 16'h0001,
                   lend: 32'h0B0B0B0C, trail: 32'h000000FF, done_t: 12};
        tbl[3] = '{len: 6, w0: 32'hF0E0D0C0, w1: 32'h0000B0A0, nw: 2, nd: 16'h1122,
                   lend: 32'h0C0C0D0D, trail: 32'h00000000, done_t: 13};
        tbl[4] = '{len: 4, w0: 32'h44332211, w1: 32'h00000000, nw: 1, nd: 16'h1111,
                   lend: 32'h0C0C0C0C, trail: 32'hFFFFFFFF, done_t: 12};

        pkt_if.start      = 1'b0;
        pkt_if.packet_len = '0;
        pkt_if.data       = '0;
        pkt_if.data_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset lane_byte", 0, 64'(lane_byte), 64'(0));
        chk("reset lane_valid", 0, 64'(lane_valid), 64'(0));
        chk("reset busy", 0, 64'(busy), 64'(0));
        chk("reset done", 0, 64'(done), 64'(0));
        chk("reset ready", 0, 64'(pkt_if.data_ready), 64'(0));
        chk("reset underrun", 0, 64'(underrun), 64'(0));
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            run_rec(tbl[k], $sformatf("rec%0d", k));
        end

        // Zero-length start is ignored
        @(negedge clk);
        pkt_if.start      = 1'b1;
        pkt_if.packet_len = 16'd0;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            pkt_if.start = 1'b0;
            chk("len0 busy", t, 64'(busy), 64'(0));
            chk("len0 lane_valid", t, 64'(lane_valid), 64'(0));
        end

        // Underrun: data_valid low for the first two DATA cycles
        @(negedge clk);
        pkt_if.start      = 1'b1;
        pkt_if.packet_len = 16'd8;
        pkt_if.data_valid = 1'b0;
        begin
            int          ptr;
            logic [31:0] eb;
            logic [3:0]  ev;
            ptr = 0;
            for (int t = 1; t <= 17; t++) begin
                @(negedge clk);
                pkt_if.start = 1'b0;
                if (t <= 6)       begin eb = 32'h00000000; ev = 4'hF; end
                else if (t == 7)  begin eb = 32'hB8B8B8B8; ev = 4'hF; end
                else if (t <= 9)  begin eb = 32'h00000000; ev = 4'hF; end
                else if (t == 10) begin eb = 32'h03020100; ev = 4'hF; end
                else if (t == 11) begin eb = 32'h07060504; ev = 4'hF; end
                else if (t <= 15) begin eb = 32'hFFFFFFFF; ev = 4'hF; end
                else              begin eb = 32'h00000000; ev = 4'h0; end
                chk("urun lane_byte", t, 64'(lane_byte), 64'(eb));
                chk("urun lane_valid", t, 64'(lane_valid), 64'(ev));
                chk("urun done", t, 64'(done), 64'(t == 15));
                chk("urun flag", t, 64'(underrun), 64'(t >= 8));
                chk("urun busy", t, 64'(busy), 64'(t <= 15));
                pkt_if.data_valid = !(t == 7 || t == 8);
                pkt_if.data       = (ptr == 0) ? 32'h03020100 : 32'h07060504;
                if (pkt_if.data_ready && pkt_if.data_valid) ptr++;
            end
        end

        // Next accepted start clears the sticky underrun flag
        @(negedge clk);
        pkt_if.start      = 1'b1;
        pkt_if.packet_len = 16'd1;
        pkt_if.data       = 32'h0000007F;
        pkt_if.data_valid = 1'b1;
        @(negedge clk);
        pkt_if.start = 1'b0;
        chk("urun clear", 1, 64'(underrun), 64'(0));
        chk("urun clear busy", 1, 64'(busy), 64'(1));
        repeat (14) @(negedge clk);
        chk("urun clear idle", 15, 64'(busy), 64'(0));

        // Reset while the sync byte is being prepared
        pkt_if.start      = 1'b1;
        pkt_if.packet_len = 16'd4;
        for (int t = 1; t <= 6; t++) begin
            @(negedge clk);
            pkt_if.start = 1'b0;
        end
        chk("pre-rst lane_valid", 6, 64'(lane_valid), 64'(4'hF));
        #1 rst = 1'b1;
        #1;
        chk("midrst lane_valid", 6, 64'(lane_valid), 64'(0));
        chk("midrst lane_byte", 6, 64'(lane_byte), 64'(0));
        chk("midrst busy", 6, 64'(busy), 64'(0));
        chk("midrst ready", 6, 64'(pkt_if.data_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst lane_valid", 0, 64'(lane_valid), 64'(0));
        run_rec(tbl[4], "rec4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
